// File: rtl/uctl_cmd_mem_bridge_if.sv
// rtl/uctl_cmd_mem_bridge_if.sv - channel, data and memory handshake bundle for the command/memory bridge
interface uctl_cmd_mem_bridge_if #(
  parameter int N_CH   = 2,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int LEN_W  = 20
);
  logic [N_CH-1:0]        ch_req;
  logic [N_CH-1:0]        ch_wrRd;
  logic [N_CH*ADDR_W-1:0] ch_addr;
  logic [N_CH*LEN_W-1:0]  ch_len;
  logic [N_CH*ADDR_W-1:0] ch_bufStart;
  logic [N_CH*ADDR_W-1:0] ch_bufEnd;
  logic [N_CH-1:0]        ch_dn;

  logic                   wrData_req;
  logic [DATA_W-1:0]      wrData;
  logic                   wrData_ack;

  logic                   rdData_vld;
  logic [DATA_W-1:0]      rdData;
  logic                   rdData_rdy;

  logic                   mem_req;
  logic                   mem_wrRd;
  logic [ADDR_W-1:0]      mem_addr;
  logic [DATA_W-1:0]      mem_wrData;
  logic                   mem_ack;
  logic                   mem_rdVal;
  logic [DATA_W-1:0]      mem_rdData;

  modport master (
    input  ch_req, ch_wrRd, ch_addr, ch_len, ch_bufStart, ch_bufEnd,
    output ch_dn,
    input  wrData_req, wrData,
    output wrData_ack,
    output rdData_vld, rdData,
    input  rdData_rdy,
    output mem_req, mem_wrRd, mem_addr, mem_wrData,
    input  mem_ack, mem_rdVal, mem_rdData
  );

  modport slave (
    output ch_req, ch_wrRd, ch_addr, ch_len, ch_bufStart, ch_bufEnd,
    input  ch_dn,
    output wrData_req, wrData,
    input  wrData_ack,
    input  rdData_vld, rdData,
    output rdData_rdy,
    input  mem_req, mem_wrRd, mem_addr, mem_wrData,
    output mem_ack, mem_rdVal, mem_rdData
  );
endinterface

// File: rtl/uctl_cmd_mem_bridge.sv
// rtl/uctl_cmd_mem_bridge.sv - round-robin multi-channel bridge moving words between channel data ports and a single-outstanding memory port
module uctl_cmd_mem_bridge #(
  parameter int N_CH   = 2,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int LEN_W  = 20
) (
  input  logic sys_clk,
  input  logic sysRst_n,
  input  logic sw_rst,
  output logic busy,
  uctl_cmd_mem_bridge_if.master bus
);
  localparam int BPW    = DATA_W / 8;
  localparam int BPW_SH = $clog2(BPW);
  localparam int PTR_W  = (N_CH > 1) ? $clog2(N_CH) : 1;

  typedef enum logic [2:0] {IDLE, ARB, WDAT, MREQ, RWAIT, RHOLD, DONE} state_t;
  state_t state_q, state_d;

  logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d, gnt_q, gnt_d, arb_idx, cand;
  logic              arb_hit;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] cur_addr_q, cur_addr_d, buf_start_q, buf_start_d, buf_end_q, buf_end_d;
  logic [ADDR_W-1:0] addr_sum, addr_next;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic [LEN_W:0]    words;
  logic [DATA_W-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic              last_word, run;

  logic [ADDR_W-1:0] addr_arr  [N_CH];
  logic [ADDR_W-1:0] start_arr [N_CH];
  logic [ADDR_W-1:0] end_arr   [N_CH];
  logic [LEN_W-1:0]  len_arr   [N_CH];

  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      addr_arr[i]  = bus.ch_addr[i*ADDR_W +: ADDR_W];
      start_arr[i] = bus.ch_bufStart[i*ADDR_W +: ADDR_W];
      end_arr[i]   = bus.ch_bufEnd[i*ADDR_W +: ADDR_W];
      len_arr[i]   = bus.ch_len[i*LEN_W +: LEN_W];
    end
  end

  // First requester at or after rr_ptr, wrapping modulo N_CH.
  always_comb begin
    arb_hit = 1'b0;
    arb_idx = '0;
    cand    = '0;
    for (int i = 0; i < N_CH; i++) begin
      cand = PTR_W'((int'(rr_ptr_q) + i) % N_CH);
      if (!arb_hit && bus.ch_req[cand]) begin
        arb_hit = 1'b1;
        arb_idx = cand;
      end
    end
  end

  assign words     = ({1'b0, len_arr[arb_idx]} + (LEN_W+1)'(BPW - 1)) >> BPW_SH;
  assign last_word = (cnt_q == LEN_W'(1));
  assign addr_sum  = cur_addr_q + ADDR_W'(BPW);
  // An empty or inverted buffer window means plain linear addressing.
  assign addr_next = ((buf_end_q > buf_start_q) && (addr_sum >= buf_end_q)) ? buf_start_q : addr_sum;

  always_ff @(posedge sys_clk or negedge sysRst_n) begin
    if (!sysRst_n) state_q <= IDLE;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (|bus.ch_req) state_d = ARB;
      ARB: begin
        if (!arb_hit)                     state_d = IDLE;
        else if (len_arr[arb_idx] == '0)  state_d = DONE;
        else if (bus.ch_wrRd[arb_idx])    state_d = WDAT;
        else                              state_d = MREQ;
      end
      WDAT:  if (bus.wrData_req) state_d = MREQ;
      MREQ: begin
        if (bus.mem_ack) begin
          if (wr_q) state_d = last_word ? DONE : WDAT;
          else      state_d = bus.mem_rdVal ? RHOLD : RWAIT;
        end
      end
      RWAIT: if (bus.mem_rdVal) state_d = RHOLD;
      RHOLD: if (bus.rdData_rdy) state_d = last_word ? DONE : MREQ;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (sw_rst) state_d = IDLE;
  end

  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    gnt_d       = gnt_q;
    wr_d        = wr_q;
    cur_addr_d  = cur_addr_q;
    buf_start_d = buf_start_q;
    buf_end_d   = buf_end_q;
    cnt_d       = cnt_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    case (state_q)
      ARB: if (arb_hit) begin
        rr_ptr_d    = PTR_W'((int'(arb_idx) + 1) % N_CH);
        gnt_d       = arb_idx;
        wr_d        = bus.ch_wrRd[arb_idx];
        cur_addr_d  = addr_arr[arb_idx];
        buf_start_d = start_arr[arb_idx];
        buf_end_d   = end_arr[arb_idx];
        cnt_d       = LEN_W'(words);
      end
      WDAT: if (bus.wrData_req) wdata_d = bus.wrData;
      MREQ: if (bus.mem_ack) begin
        if (wr_q) begin
          cur_addr_d = addr_next;
          cnt_d      = cnt_q - LEN_W'(1);
        end else if (bus.mem_rdVal) begin
          rdata_d = bus.mem_rdData;
        end
      end
      RWAIT: if (bus.mem_rdVal) rdata_d = bus.mem_rdData;
      RHOLD: if (bus.rdData_rdy) begin
        cur_addr_d = addr_next;
        cnt_d      = cnt_q - LEN_W'(1);
      end
      default: ;
    endcase
    if (sw_rst) begin
      rr_ptr_d    = '0;
      gnt_d       = '0;
      wr_d        = 1'b0;
      cur_addr_d  = '0;
      buf_start_d = '0;
      buf_end_d   = '0;
      cnt_d       = '0;
      wdata_d     = '0;
      rdata_d     = '0;
    end
  end

  always_ff @(posedge sys_clk or negedge sysRst_n) begin
    if (!sysRst_n) begin
      rr_ptr_q    <= '0;
      gnt_q       <= '0;
      wr_q        <= 1'b0;
      cur_addr_q  <= '0;
      buf_start_q <= '0;
      buf_end_q   <= '0;
      cnt_q       <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      gnt_q       <= gnt_d;
      wr_q        <= wr_d;
      cur_addr_q  <= cur_addr_d;
      buf_start_q <= buf_start_d;
      buf_end_q   <= buf_end_d;
      cnt_q       <= cnt_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
    end
  end

  // Handshake outputs are suppressed during a soft reset cycle so nothing is accepted that is about to be discarded.
  always_comb begin
    run            = !sw_rst;
    busy           = (state_q != IDLE);
    bus.mem_req    = run && (state_q == MREQ);
    bus.mem_wrRd   = bus.mem_req && wr_q;
    bus.mem_addr   = bus.mem_req ? cur_addr_q : '0;
    bus.mem_wrData = bus.mem_wrRd ? wdata_q : '0;
    bus.wrData_ack = run && (state_q == WDAT) && bus.wrData_req;
    bus.rdData_vld = run && (state_q == RHOLD);
    bus.rdData     = rdata_q;
    bus.ch_dn      = '0;
    if (run && (state_q == DONE)) bus.ch_dn[gnt_q] = 1'b1;
  end
endmodule

// File: tb/tb_uctl_cmd_mem_bridge.sv
// tb/tb_uctl_cmd_mem_bridge.sv - self-checking bench for uctl_cmd_mem_bridge
module tb_uctl_cmd_mem_bridge;
  localparam int N_CH = 2, DATA_W = 32, ADDR_W = 32, LEN_W = 20;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sw_rst = 1'b0;
  logic busy;
  always #5 clk = ~clk;

  uctl_cmd_mem_bridge_if #(.N_CH(N_CH), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .LEN_W(LEN_W)) bus();

  uctl_cmd_mem_bridge #(.N_CH(N_CH), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
    .sys_clk(clk), .sysRst_n(rst_n), .sw_rst(sw_rst), .busy(busy), .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  int ack_pct, rdv_same_pct, rdv_pct, rdy_pct, rdy_stall, wreq_pct;
  bit drop_on_done, scramble;

  logic [31:0] acc_addr_q[$];
  bit          acc_wr_q[$];
  logic [31:0] acc_data_q[$];
  logic [31:0] wcap_q[$];
  logic [31:0] rsup_q[$];
  logic [31:0] rrcv_q[$];
  int          dn_q[$];

  typedef struct {
    bit          wr;
    int          ch;
    logic [31:0] addr;
    logic [19:0] len;
    logic [31:0] bs;
    logic [31:0] be;
    int          stall;
    int          exp_n;
    logic [31:0] exp_first;
    logic [31:0] exp_last;
  } vec_t;
  vec_t vt[7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model_addr(input logic [31:0] a0, input logic [31:0] bs,
                                             input logic [31:0] be, input int k);
    logic [31:0] a;
    a = a0;
    for (int i = 0; i < k; i++) begin
      a = a + 32'd4;
      if (be > bs && a >= be) a = bs;
    end
    return a;
  endfunction

  task automatic clear_q();
    acc_addr_q.delete(); acc_wr_q.delete(); acc_data_q.delete();
    wcap_q.delete(); rsup_q.delete(); rrcv_q.delete(); dn_q.delete();
  endtask

  task automatic set_ch(input int ch, input bit wr, input logic [31:0] addr, input logic [19:0] len,
                        input logic [31:0] bs, input logic [31:0] be);
    bus.ch_wrRd[ch]                  = wr;
    bus.ch_addr[ch*ADDR_W +: ADDR_W] = addr;
    bus.ch_len[ch*LEN_W +: LEN_W]    = len;
    bus.ch_bufStart[ch*ADDR_W +: ADDR_W] = bs;
    bus.ch_bufEnd[ch*ADDR_W +: ADDR_W]   = be;
  endtask

  task automatic knobs(input int ack, input int rsame, input int rdv, input int rdy, input int stall,
                       input int wreq, input bit scr);
    ack_pct = ack; rdv_same_pct = rsame; rdv_pct = rdv; rdy_pct = rdy;
    rdy_stall = stall; wreq_pct = wreq; scramble = scr;
  endtask

  // Acts as data source, data sink and memory until n_done completions are seen.
  task automatic serve(input int n_done, input int budget);
    int done_cnt, cyc, vld_cyc;
    bit rd_pend, scrambled;
    logic [31:0] hold, v;
    done_cnt = 0; cyc = 0; vld_cyc = 0; rd_pend = 0; scrambled = 0; hold = '0;
    while (done_cnt < n_done && cyc < budget) begin
      @(negedge clk);
      cyc++;
      bus.mem_ack = 1'b0; bus.mem_rdVal = 1'b0; bus.rdData_rdy = 1'b0;
      bus.wrData = $urandom;
      bus.wrData_req = ($urandom_range(0, 99) < wreq_pct);
      if (|bus.ch_dn) begin
        done_cnt++;
        for (int c = 0; c < N_CH; c++)
          if (bus.ch_dn[c]) begin
            dn_q.push_back(c);
            if (drop_on_done) bus.ch_req[c] = 1'b0;
          end
      end
      if (bus.mem_req) begin
        if (scramble && !scrambled) begin
          for (int c = 0; c < N_CH; c++)
            set_ch(c, 1'($urandom), $urandom, 20'($urandom), $urandom, $urandom);
          scrambled = 1;
        end
        if ($urandom_range(0, 99) < ack_pct) begin
          bus.mem_ack = 1'b1;
          acc_addr_q.push_back(bus.mem_addr);
          acc_wr_q.push_back(bus.mem_wrRd);
          acc_data_q.push_back(bus.mem_wrData);
          if (!bus.mem_wrRd) begin
            if ($urandom_range(0, 99) < rdv_same_pct) begin
              v = $urandom; bus.mem_rdVal = 1'b1; bus.mem_rdData = v; rsup_q.push_back(v);
            end else rd_pend = 1;
          end
        end
      end else if (rd_pend && $urandom_range(0, 99) < rdv_pct) begin
        v = $urandom; bus.mem_rdVal = 1'b1; bus.mem_rdData = v; rsup_q.push_back(v);
        rd_pend = 0;
      end
      if (bus.rdData_vld) begin
        if (vld_cyc > 0) chk("rd_hold", bus.rdData, hold);
        hold = bus.rdData;
        vld_cyc++;
        if (vld_cyc > rdy_stall && $urandom_range(0, 99) < rdy_pct) begin
          bus.rdData_rdy = 1'b1;
          rrcv_q.push_back(bus.rdData);
          vld_cyc = 0;
        end
      end
      #1;
      if (bus.wrData_ack) wcap_q.push_back(bus.wrData);
    end
    chk("serve_done", done_cnt, n_done);
  endtask

  task automatic run_xfer(input int ch, input bit wr, input logic [31:0] addr, input logic [19:0] len,
                          input logic [31:0] bs, input logic [31:0] be);
    set_ch(ch, wr, addr, len, bs, be);
    clear_q();
    drop_on_done = 1;
    bus.ch_req = '0;
    bus.ch_req[ch] = 1'b1;
    serve(1, 3000);
  endtask

  task automatic check_xfer(input string tag, input int ch, input bit wr, input logic [31:0] addr,
                            input logic [19:0] len, input logic [31:0] bs, input logic [31:0] be);
    int w;
    w = (int'(len) + 3) / 4;
    chk({tag, "_n_acc"}, acc_addr_q.size(), w);
    for (int k = 0; k < w && k < acc_addr_q.size(); k++) begin
      chk($sformatf("%s_addr%0d", tag, k), acc_addr_q[k], model_addr(addr, bs, be, k));
      chk($sformatf("%s_wrrd%0d", tag, k), acc_wr_q[k], wr);
    end
    if (wr) begin
      chk({tag, "_n_wcap"}, wcap_q.size(), w);
      for (int k = 0; k < w && k < wcap_q.size() && k < acc_data_q.size(); k++)
        chk($sformatf("%s_wdata%0d", tag, k), acc_data_q[k], wcap_q[k]);
    end else begin
      chk({tag, "_n_rd"}, rrcv_q.size(), w);
      for (int k = 0; k < w && k < rrcv_q.size() && k < rsup_q.size(); k++)
        chk($sformatf("%s_rdata%0d", tag, k), rrcv_q[k], rsup_q[k]);
    end
    chk({tag, "_n_dn"}, dn_q.size(), 1);
    if (dn_q.size() > 0) chk({tag, "_dn_ch"}, dn_q[0], ch);
  endtask

  initial begin
    int exp_order[4];
    logic [31:0] exp_gaddr[4];
    bit saw;
    int ch, span;
    bit wr;
    logic [31:0] addr, bs, be;
    logic [19:0] len;

    bus.ch_req = '0; bus.ch_wrRd = '0; bus.ch_addr = '0; bus.ch_len = '0;
    bus.ch_bufStart = '0; bus.ch_bufEnd = '0;
    bus.wrData_req = 1'b0; bus.wrData = '0; bus.rdData_rdy = 1'b0;
    bus.mem_ack = 1'b0; bus.mem_rdVal = 1'b0; bus.mem_rdData = '0;
    knobs(100, 100, 100, 100, 0, 100, 0);
    drop_on_done = 1;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_mem_req", bus.mem_req, 0);
    chk("rst_mem_wrRd", bus.mem_wrRd, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_mem_wrData", bus.mem_wrData, 0);
    chk("rst_wrData_ack", bus.wrData_ack, 0);
    chk("rst_rdData_vld", bus.rdData_vld, 0);
    chk("rst_rdData", bus.rdData, 0);
    chk("rst_ch_dn", bus.ch_dn, 0);
    chk("rst_busy", busy, 0);

    // Both channels requesting from reset: rotating grants
    set_ch(0, 1, 32'h0, 20'd4, 32'h0, 32'h0);
    set_ch(1, 1, 32'h800, 20'd4, 32'h0, 32'h0);
    clear_q();
    bus.ch_req = 2'b11;
    drop_on_done = 0;
    rst_n = 1'b1;
    serve(4, 1000);
    bus.ch_req = '0;
    exp_order = '{0, 1, 0, 1};
    exp_gaddr = '{32'h0, 32'h800, 32'h0, 32'h800};
    chk("rr_n_dn", dn_q.size(), 4);
    chk("rr_n_acc", acc_addr_q.size(), 4);
    for (int i = 0; i < 4 && i < dn_q.size(); i++) chk($sformatf("rr_order%0d", i), dn_q[i], exp_order[i]);
    for (int i = 0; i < 4 && i < acc_addr_q.size(); i++) chk($sformatf("rr_addr%0d", i), acc_addr_q[i], exp_gaddr[i]);

    // Directed vectors
    vt[0] = '{1, 0, 32'h100,      20'd8,  32'h0,   32'h1000, 0, 2, 32'h100,      32'h104};
    vt[1] = '{0, 1, 32'hFF8,      20'd12, 32'hF00, 32'h1000, 3, 3, 32'hFF8,      32'hF00};
    vt[2] = '{1, 0, 32'h200,      20'd0,  32'h0,   32'h1000, 0, 0, 32'h0,        32'h0};
    vt[3] = '{0, 0, 32'h300,      20'd5,  32'h0,   32'h0,    0, 2, 32'h300,      32'h304};
    vt[4] = '{1, 1, 32'hFFFFFFFC, 20'd8,  32'h10,  32'h10,   0, 2, 32'hFFFFFFFC, 32'h0};
    vt[5] = '{0, 1, 32'h1C,       20'd1,  32'h10,  32'h20,   1, 1, 32'h1C,       32'h1C};
    vt[6] = '{1, 0, 32'h1C,       20'd12, 32'h10,  32'h20,   0, 3, 32'h1C,       32'h14};
    for (int i = 0; i < 7; i++) begin
      knobs(100, 100, 100, 100, vt[i].stall, 100, 0);
      run_xfer(vt[i].ch, vt[i].wr, vt[i].addr, vt[i].len, vt[i].bs, vt[i].be);
      chk($sformatf("v%0d_n", i), acc_addr_q.size(), vt[i].exp_n);
      if (vt[i].exp_n > 0 && acc_addr_q.size() > 0) begin
        chk($sformatf("v%0d_first", i), acc_addr_q[0], vt[i].exp_first);
        chk($sformatf("v%0d_last", i), acc_addr_q[acc_addr_q.size()-1], vt[i].exp_last);
      end
      check_xfer($sformatf("v%0d", i), vt[i].ch, vt[i].wr, vt[i].addr, vt[i].len, vt[i].bs, vt[i].be);
    end

    // Request withdrawn while in ARB
    @(negedge clk);
    set_ch(1, 1, 32'h40, 20'd4, 32'h0, 32'h0);
    bus.ch_req = 2'b10;
    @(negedge clk);
    chk("wd_busy_arb", busy, 1);
    bus.ch_req = '0;
    saw = 0;
    repeat (3) begin
      @(negedge clk);
      if (bus.mem_req || |bus.ch_dn || bus.wrData_ack) saw = 1;
    end
    chk("wd_no_activity", saw, 0);
    chk("wd_busy_idle", busy, 0);

    // Soft reset in RWAIT, read data arrives afterwards
    set_ch(0, 0, 32'h40, 20'd4, 32'h0, 32'h0);
    bus.ch_req = 2'b01;
    saw = 0;
    for (int i = 0; i < 20 && !saw; i++) begin
      @(negedge clk);
      saw = bus.mem_req;
    end
    chk("sw_mreq_seen", saw, 1);
    bus.mem_ack = 1'b1; bus.mem_rdVal = 1'b0; bus.ch_req = '0;
    @(negedge clk);
    bus.mem_ack = 1'b0;
    chk("sw_busy_rwait", busy, 1);
    sw_rst = 1'b1;
    @(negedge clk);
    sw_rst = 1'b0;
    bus.mem_rdVal = 1'b1; bus.mem_rdData = 32'hDEADBEEF;
    #1;
    chk("sw_busy", busy, 0);
    chk("sw_mem_req", bus.mem_req, 0);
    chk("sw_mem_addr", bus.mem_addr, 0);
    chk("sw_rdData_vld", bus.rdData_vld, 0);
    chk("sw_ch_dn", bus.ch_dn, 0);
    @(negedge clk);
    bus.mem_rdVal = 1'b0;
    chk("sw_late_vld", bus.rdData_vld, 0);
    chk("sw_late_rdData", bus.rdData, 0);
    chk("sw_late_busy", busy, 0);

    // Asynchronous reset while a write waits in MREQ
    knobs(0, 0, 0, 0, 0, 100, 0);
    set_ch(0, 1, 32'h500, 20'd8, 32'h0, 32'h0);
    bus.wrData_req = 1'b1;
    bus.ch_req = 2'b01;
    saw = 0;
    for (int i = 0; i < 20 && !saw; i++) begin
      @(negedge clk);
      saw = bus.mem_req;
    end
    chk("ar_mreq_seen", saw, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_mem_req", bus.mem_req, 0);
    chk("ar_mem_addr", bus.mem_addr, 0);
    chk("ar_mem_wrData", bus.mem_wrData, 0);
    chk("ar_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1; bus.ch_req = '0; bus.mem_ack = 1'b1;
    saw = 0;
    repeat (4) begin
      @(negedge clk);
      bus.mem_ack = 1'b0;
      if (|bus.ch_dn || busy || bus.mem_req) saw = 1;
    end
    chk("ar_no_activity", saw, 0);

    // Randomized transfers against the address/data model
    for (int it = 0; it < 25; it++) begin
      ch = $urandom_range(0, N_CH - 1);
      wr = 1'($urandom_range(0, 1));
      len = 20'($urandom_range(0, 40));
      if ($urandom_range(0, 1) == 1) begin
        bs = $urandom_range(0, 1023) * 4;
        span = $urandom_range(1, 16);
        be = bs + span * 4;
        addr = bs + $urandom_range(0, span - 1) * 4;
      end else begin
        bs = $urandom_range(0, 15) * 4;
        be = bs - $urandom_range(0, 2) * 4;
        addr = $urandom;
        addr[1:0] = 2'b00;
      end
      knobs($urandom_range(30, 100), $urandom_range(0, 100), $urandom_range(30, 100),
            $urandom_range(30, 100), $urandom_range(0, 2), $urandom_range(40, 100), 1);
      run_xfer(ch, wr, addr, len, bs, be);
      check_xfer($sformatf("r%0d", it), ch, wr, addr, len, bs, be);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
